// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcodes, format codes, FSM states and the stored entry layout for the
// immediate-generation stage. Entry fields are sized for the widest XLEN.
package imm_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_CSR  = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic [XLEN_MAX-1:0] target;
        logic                unknown;
    } entry_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the immediate-generation stage.
// master drives instructions in and accepts results; slave is the stage itself.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    import imm_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_unknown;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt,
               out_target, out_unknown
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt,
               out_target, out_unknown
    );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I immediate decoder: opcode -> format, extended immediate, unknown.
// Build macro IMM_ZICSR_EN adds the CSR-immediate (uimm) format for SYSTEM opcodes.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output fmt_e            o_fmt,
    output logic [XLEN-1:0] o_imm,
    output logic            o_unknown
);

    logic [2:0]         w_funct3;
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [20:0] w_imm_j;

    assign w_funct3 = i_instr[14:12];
    assign w_imm_i  = i_instr[31:20];
    assign w_imm_s  = {i_instr[31:25], i_instr[11:7]};
    assign w_imm_b  = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u  = {i_instr[31:12], 12'b0};
    assign w_imm_j  = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        o_fmt     = FMT_NONE;
        o_imm     = '0;
        o_unknown = 1'b0;
        unique case (i_instr[6:0])
            OPC_OP_IMM: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    o_fmt = FMT_SH;
                    // RV64 shifts carry a 6-bit shamt; bit 25 is funct7 on RV32
                    if (XLEN == 64) o_imm = XLEN'(i_instr[25:20]);
                    else            o_imm = XLEN'(i_instr[24:20]);
                end else begin
                    o_fmt = FMT_I;
                    o_imm = XLEN'(w_imm_i);
                end
            end
            OPC_LOAD, OPC_JALR: begin
                o_fmt = FMT_I;
                o_imm = XLEN'(w_imm_i);
            end
            OPC_STORE: begin
                o_fmt = FMT_S;
                o_imm = XLEN'(w_imm_s);
            end
            OPC_BRANCH: begin
                o_fmt = FMT_B;
                o_imm = XLEN'(w_imm_b);
            end
            OPC_LUI, OPC_AUIPC: begin
                o_fmt = FMT_U;
                o_imm = XLEN'(w_imm_u);
            end
            OPC_JAL: begin
                o_fmt = FMT_J;
                o_imm = XLEN'(w_imm_j);
            end
`ifdef IMM_ZICSR_EN
            OPC_SYSTEM: begin
                if (w_funct3[2]) begin
                    o_fmt = FMT_CSR;
                    o_imm = XLEN'(i_instr[19:15]);
                end else begin
                    o_unknown = 1'b1;
                end
            end
`endif
            default: o_unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decode at input, pc-relative target add,
// two-entry skid buffer. Build macro IMM_ZICSR_EN enables CSR-immediate decoding.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    function automatic logic [XLEN-1:0] add_wrap(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        return a + b;
    endfunction

    fmt_e            w_fmt_p0;
    logic [XLEN-1:0] w_imm_p0;
    logic            w_unknown_p0;
    logic            w_pcrel_p0;
    entry_t          w_entry_p0;
    logic            w_in_fire;
    logic            w_out_fire;

    state_e          r_state;
    logic            r_out_valid;
    logic            r_in_ready;
    entry_t          r_out_p1;
    entry_t          r_skid_p1;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_instr   (bus.in_instr),
        .o_fmt     (w_fmt_p0),
        .o_imm     (w_imm_p0),
        .o_unknown (w_unknown_p0)
    );

    // p0: decoded entry built combinationally from the incoming instruction
    assign w_pcrel_p0 = (w_fmt_p0 == FMT_B) || (w_fmt_p0 == FMT_J) ||
                        (bus.in_instr[6:0] == OPC_AUIPC);

    always_comb begin
        w_entry_p0         = '0;
        w_entry_p0.instr   = bus.in_instr;
        w_entry_p0.pc      = XLEN_MAX'(bus.in_pc);
        w_entry_p0.imm     = XLEN_MAX'(w_imm_p0);
        w_entry_p0.fmt     = w_fmt_p0;
        w_entry_p0.target  = w_pcrel_p0 ? XLEN_MAX'(add_wrap(bus.in_pc, w_imm_p0)) : '0;
        w_entry_p0.unknown = w_unknown_p0;
    end

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    // p1: output register plus skid slot; in_ready depends only on held state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_p1    <= '0;
            r_skid_p1   <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_out_p1    <= w_entry_p0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        r_skid_p1  <= w_entry_p0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_TWO;
                    end else if (w_in_fire && w_out_fire) begin
                        r_out_p1 <= w_entry_p0;
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_out_p1   <= r_skid_p1;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_instr   = r_out_p1.instr;
    assign bus.out_pc      = r_out_p1.pc[XLEN-1:0];
    assign bus.out_imm     = r_out_p1.imm[XLEN-1:0];
    assign bus.out_fmt     = r_out_p1.fmt;
    assign bus.out_target  = r_out_p1.target[XLEN-1:0];
    assign bus.out_unknown = r_out_p1.unknown;

    if (XLEN < XLEN_MAX) begin : g_narrow
        logic w_unused_hi;
        assign w_unused_hi = ^{r_out_p1.pc[XLEN_MAX-1:XLEN],
                               r_out_p1.imm[XLEN_MAX-1:XLEN],
                               r_out_p1.target[XLEN_MAX-1:XLEN]};
    end

endmodule
